// File: rtl/sa_ws_array.sv
// sa_ws_array: ROWS x COLS weight-stationary systolic array with indexed weight
// loading, input skew, output deskew and an IDLE/LOAD/RUN/DRAIN controller.
module sa_ws_array #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [COLS*DW-1:0]   w_data,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [ROWS*DW-1:0]   act_data,
  output logic                 out_valid,
  output logic [COLS*AW-1:0]   out_data,
  output logic                 busy
);
  localparam int LAT = ROWS + COLS;
  localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [COLS*DW-1:0] r_w [ROWS];
  logic [LAT-1:0]     r_vld;
  logic               w_w_acc;
  logic               w_a_acc;
  logic [DW-1:0]      w_sk_out [ROWS];
  logic [DW-1:0]      r_pe_a [ROWS][COLS];
  logic [AW-1:0]      r_pe_p [ROWS][COLS];
  logic [COLS*AW-1:0] w_res;

  assign w_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
  // A pending reload blocks new activations in the same cycle.
  assign act_ready = (r_state == S_RUN) && !w_valid;
  assign w_w_acc   = w_valid && w_ready;
  assign w_a_acc   = act_valid && act_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < ROWS; i++) r_w[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_w_acc) begin
          r_w[0] <= w_data;
          if (ROWS == 1) begin
            r_state <= S_RUN;
          end else begin
            r_cnt   <= CW'(1);
            r_state <= S_LOAD;
          end
        end
        S_LOAD: if (w_w_acc) begin
          r_w[r_cnt] <= w_data;
          if (r_cnt == CW'(ROWS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RUN:   if (w_valid) r_state <= S_DRAIN;
        S_DRAIN: if (r_vld == '0) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      r_vld     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      r_vld     <= {r_vld[LAT-2:0], w_a_acc};
      busy      <= |r_vld;
      out_valid <= r_vld[LAT-1];
      if (r_vld[LAT-1]) out_data <= w_res;
    end
  end

  // Row gi sees its activation gi cycles late so wavefronts meet diagonally.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
    logic [DW-1:0] r_sk [gi+1];
    always_ff @(posedge clk) begin
      if (!rst || clear) begin
        for (int k = 0; k <= gi; k++) r_sk[k] <= '0;
      end else begin
        r_sk[0] <= w_a_acc ? act_data[gi*DW +: DW] : '0;
        for (int k = 1; k <= gi; k++) r_sk[k] <= r_sk[k-1];
      end
    end
    assign w_sk_out[gi] = r_sk[gi];
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic [DW-1:0]          w_a_in;
      logic [AW-1:0]          w_p_in;
      logic signed [2*DW-1:0] w_prod;
      if (gj == 0) begin : g_a_edge
        assign w_a_in = w_sk_out[gi];
      end else begin : g_a_chain
        assign w_a_in = r_pe_a[gi][gj-1];
      end
      if (gi == 0) begin : g_p_edge
        assign w_p_in = '0;
      end else begin : g_p_chain
        assign w_p_in = r_pe_p[gi-1][gj];
      end
      assign w_prod = $signed(w_a_in) * $signed(r_w[gi][gj*DW +: DW]);
      always_ff @(posedge clk) begin
        if (!rst || clear) begin
          r_pe_a[gi][gj] <= '0;
          r_pe_p[gi][gj] <= '0;
        end else begin
          r_pe_a[gi][gj] <= w_a_in;
          r_pe_p[gi][gj] <= w_p_in + AW'(w_prod);
        end
      end
    end
  end

  // Column gj finishes gj cycles after column 0; pad so all columns line up.
  for (genvar gj = 0; gj < COLS; gj++) begin : g_dsk
    localparam int D = COLS - 1 - gj;
    if (D == 0) begin : g_pass
      assign w_res[gj*AW +: AW] = r_pe_p[ROWS-1][gj];
    end else begin : g_dly
      logic [AW-1:0] r_ds [D];
      always_ff @(posedge clk) begin
        if (!rst || clear) begin
          for (int k = 0; k < D; k++) r_ds[k] <= '0;
        end else begin
          r_ds[0] <= r_pe_p[ROWS-1][gj];
          for (int k = 1; k < D; k++) r_ds[k] <= r_ds[k-1];
        end
      end
      assign w_res[gj*AW +: AW] = r_ds[D-1];
    end
  end

endmodule

// File: tb/tb_sa_ws_array.sv
// Directed/random bench for sa_ws_array: every accepted vector is scored by an
// arithmetic model and scheduled LAT edges later; outputs are checked each cycle.
module tb_sa_ws_array;
  localparam int ROWS = 4, COLS = 4, DW = 8, AW = 24, LAT = ROWS + COLS, NMAX = 1024;
  localparam int YW = COLS * AW;

  logic clk = 1'b0;
  logic rst = 1'b0, clear = 1'b0, w_valid = 1'b0, act_valid = 1'b0;
  logic [COLS*DW-1:0] w_data = '0;
  logic [ROWS*DW-1:0] act_data = '0;
  logic w_ready, act_ready, out_valid, busy;
  logic [COLS*AW-1:0] out_data;

  sa_ws_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n = 0, n_assert = 0, n_fail = 0, n_out = 0, last_ov = -100;
  logic           sv [NMAX];
  logic [YW-1:0]  sy [NMAX];
  logic [YW-1:0]  last_y = '0;
  int             wm [ROWS][COLS];
  logic [COLS*DW-1:0] nw [ROWS];

  task automatic chk(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %h expected %h", tag, n, got, exp);
    end
  endtask

  function automatic logic [YW-1:0] model(input logic [ROWS*DW-1:0] a);
    logic [YW-1:0] y;
    int s;
    y = '0;
    for (int c = 0; c < COLS; c++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++) s += int'($signed(a[r*DW +: DW])) * wm[r][c];
      y[c*AW +: AW] = AW'(s);
    end
    return y;
  endfunction

  task automatic check();
    logic exp_busy;
    logic [YW-1:0] exp_y;
    exp_busy = 1'b0;
    for (int k = n; k < n + LAT; k++) if (k < NMAX && sv[k]) exp_busy = 1'b1;
    exp_y = sv[n] ? sy[n] : last_y;
    chk("out_valid", YW'(out_valid), YW'(sv[n]));
    chk("out_data", out_data, exp_y);
    chk("busy", YW'(busy), YW'(exp_busy));
    last_y = exp_y;
    if (out_valid === 1'b1) begin
      n_out++;
      last_ov = n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    #1;
    check();
  endtask

  task automatic wipe_from(input int k0);
    for (int k = k0; k < NMAX; k++) sv[k] = 1'b0;
  endtask

  task automatic send(input logic [ROWS*DW-1:0] a);
    act_valid = 1'b1;
    act_data  = a;
    w_valid   = 1'b0;
    #1;
    chk("act_ready_send", YW'(act_ready), YW'(1'b1));
    sv[n+1+LAT] = 1'b1;
    sy[n+1+LAT] = model(a);
    tick();
    act_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    act_valid = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic load(input bit chk_gap);
    int k, guard;
    bit first;
    k = 0; guard = 0; first = 1'b1;
    act_valid = 1'b0;
    while (k < ROWS && guard < 60) begin
      w_valid = 1'b1;
      w_data  = nw[k];
      #1;
      if (w_ready === 1'b1) begin
        if (first && chk_gap) chk("w_ready_after_last_out", YW'(n - last_ov), YW'(1));
        first = 1'b0;
        for (int c = 0; c < COLS; c++) wm[k][c] = int'($signed(nw[k][c*DW +: DW]));
        k++;
      end
      tick();
      guard++;
    end
    w_valid = 1'b0;
    if (k < ROWS) chk("load_timeout", YW'(k), YW'(ROWS));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0; clear = 1'b0; w_valid = 1'b0; act_valid = 1'b0;
    wipe_from(n + 1);
    last_y = '0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = 0;
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  task automatic rand_w();
    for (int r = 0; r < ROWS; r++) nw[r] = COLS*DW'({$urandom, $urandom});
  endtask

  function automatic logic [ROWS*DW-1:0] rand_a();
    return ROWS*DW'($urandom);
  endfunction

  function automatic logic [COLS*DW-1:0] fill_w(input logic [DW-1:0] v);
    logic [COLS*DW-1:0] x;
    for (int c = 0; c < COLS; c++) x[c*DW +: DW] = v;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [YW-1:0]      ky;
    logic [ROWS*DW-1:0] ka;
    for (int k = 0; k < NMAX; k++) begin
      sv[k] = 1'b0;
      sy[k] = '0;
    end

    // Power-on reset
    do_reset(3);
    chk("reset_w_ready", YW'(w_ready), YW'(1'b1));
    chk("reset_act_ready", YW'(act_ready), YW'(1'b0));

    // Identity weights, act (1,2,3,4)
    for (int r = 0; r < ROWS; r++) begin
      nw[r] = '0;
      nw[r][r*DW +: DW] = 8'd1;
    end
    load(1'b0);
    ka = {8'd4, 8'd3, 8'd2, 8'd1};
    send(ka);
    idle(LAT + 2);
    ky = {24'd4, 24'd3, 24'd2, 24'd1};
    chk("identity_y", out_data, ky);

    // Signed: -1 weights x 127
    for (int r = 0; r < ROWS; r++) nw[r] = fill_w(8'hFF);
    load(1'b0);
    send({ROWS{8'd127}});
    idle(LAT + 2);
    ky = {COLS{24'hFFFE04}};
    chk("neg_y", out_data, ky);

    // Signed: -128 x -128
    for (int r = 0; r < ROWS; r++) nw[r] = fill_w(8'h80);
    load(1'b0);
    send({ROWS{8'h80}});
    idle(LAT + 2);
    ky = {COLS{24'h010000}};
    chk("min_y", out_data, ky);

    // Streaming with a bubble on the 4th cycle
    rand_w();
    load(1'b0);
    n_out = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) idle(1);
      else send(rand_a());
    end
    idle(LAT + 2);
    chk("stream_count", YW'(n_out), YW'(9));

    // Reload requested together with an activation
    for (int i = 0; i < 3; i++) send(rand_a());
    rand_w();
    w_valid = 1'b1; w_data = nw[0]; act_valid = 1'b1; act_data = rand_a();
    #1;
    chk("reload_act_ready", YW'(act_ready), YW'(1'b0));
    chk("reload_w_ready", YW'(w_ready), YW'(1'b0));
    tick();
    act_valid = 1'b0;
    load(1'b1);
    for (int i = 0; i < 3; i++) send(rand_a());
    idle(LAT + 2);

    // Clear with vectors in flight
    for (int i = 0; i < 3; i++) send(rand_a());
    clear = 1'b1;
    wipe_from(n + 1);
    tick();
    clear = 1'b0;
    idle(2);
    chk("clear_busy", YW'(busy), YW'(1'b0));
    send(rand_a());
    idle(LAT + 2);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) send(rand_a());
    do_reset(1);
    idle(LAT + 4);
    chk("rst_w_ready", YW'(w_ready), YW'(1'b1));
    chk("rst_act_ready", YW'(act_ready), YW'(1'b0));
    chk("rst_busy", YW'(busy), YW'(1'b0));
    chk("rst_out_data", out_data, YW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
